// File: rtl/vend_pkg.sv
// Shared types and unit constants for the vending controller.
// All money values are in half-yuan units.
package vend_pkg;

    localparam int BAL_W        = 10;
    localparam int NUM_EVT      = 5;
    localparam int COIN_ONE_VAL = 2;
    localparam int COIN_TEN_VAL = 20;
    localparam int CHG_HALF_VAL = 1;

    typedef logic [BAL_W-1:0] bal_t;
    typedef logic [BAL_W:0]   sum_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_e;

    // One bit per front-panel input, in the order the edge detectors are wired.
    typedef struct packed {
        logic coin_one;
        logic coin_ten;
        logic get_one;
        logic get_two;
        logic cancel;
    } evt_t;

    // Largest change coin that does not exceed the remaining balance.
    function automatic bal_t chg_amount(input bal_t bal);
        bal_t amt;
        if (bal >= bal_t'(COIN_TEN_VAL))
            amt = bal_t'(COIN_TEN_VAL);
        else if (bal >= bal_t'(COIN_ONE_VAL))
            amt = bal_t'(COIN_ONE_VAL);
        else
            amt = bal_t'(CHG_HALF_VAL);
        return amt;
    endfunction

endpackage

// File: rtl/vend_edge_det.sv
// Registered rising-edge detector: evt pulses for one cycle the edge after
// the input is first seen high, so a held level yields a single event.
module vend_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic evt
);

    logic prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
            evt  <= 1'b0;
        end else begin
            prev <= in;
            evt  <= in & ~prev;
        end
    end

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine controller: owns the credit balance, turns front-panel levels
// into events, runs the vend strobe and pays change coin by coin.
module vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE_ONE   = 5,
    parameter int PRICE_TWO   = 10,
    parameter int MAX_BAL     = 1000,
    parameter int VEND_CYC    = 2,
    parameter int CHG_GAP     = 4,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_one,
    input  logic             coin_ten,
    input  logic             get_one,
    input  logic             get_two,
    input  logic             cancle_flag,
    output logic [BAL_W-1:0] coin_val,
    output logic [1:0]       state,
    output logic             vend_one,
    output logic             vend_two,
    output logic             chg_ten,
    output logic             chg_one,
    output logic             chg_half,
    output logic             coin_reject,
    output logic             deny,
    output logic             buy_flag
);

    localparam int VC_W  = $clog2(VEND_CYC + 1);
    localparam int GAP_W = $clog2(CHG_GAP + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    logic [NUM_EVT-1:0] raw;
    logic [NUM_EVT-1:0] evt_vec;
    evt_t               ev;

    assign raw = {coin_one, coin_ten, get_one, get_two, cancle_flag};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_EVT; gi++) begin : g_edge
            vend_edge_det u_edge (
                .clk   (clk),
                .reset (reset),
                .in    (raw[gi]),
                .evt   (evt_vec[gi])
            );
        end
    endgenerate

    assign ev = evt_t'(evt_vec);

    state_e            state_q, state_nx;
    bal_t              bal_q, bal_nx;
    logic              buy_q, buy_nx;
    logic              vend_one_q, vend_one_nx;
    logic              vend_two_q, vend_two_nx;
    logic              chg_ten_q, chg_ten_nx;
    logic              chg_one_q, chg_one_nx;
    logic              chg_half_q, chg_half_nx;
    logic              rej_q, rej_nx;
    logic              deny_q, deny_nx;
    logic [VC_W-1:0]   vcnt_q, vcnt_nx;
    logic [GAP_W-1:0]  gcnt_q, gcnt_nx;
    logic [TO_W-1:0]   tcnt_q, tcnt_nx;

    sum_t coin_sum;
    sum_t bal_coin;
    sum_t price;
    bal_t chg_amt;
    logic over;
    logic coin_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bal_q      <= '0;
            buy_q      <= 1'b0;
            vend_one_q <= 1'b0;
            vend_two_q <= 1'b0;
            chg_ten_q  <= 1'b0;
            chg_one_q  <= 1'b0;
            chg_half_q <= 1'b0;
            rej_q      <= 1'b0;
            deny_q     <= 1'b0;
            vcnt_q     <= '0;
            gcnt_q     <= '0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_nx;
            bal_q      <= bal_nx;
            buy_q      <= buy_nx;
            vend_one_q <= vend_one_nx;
            vend_two_q <= vend_two_nx;
            chg_ten_q  <= chg_ten_nx;
            chg_one_q  <= chg_one_nx;
            chg_half_q <= chg_half_nx;
            rej_q      <= rej_nx;
            deny_q     <= deny_nx;
            vcnt_q     <= vcnt_nx;
            gcnt_q     <= gcnt_nx;
            tcnt_q     <= tcnt_nx;
        end
    end

    always_comb begin
        price    = '0;
        coin_sum = (ev.coin_one ? sum_t'(COIN_ONE_VAL) : '0)
                 + (ev.coin_ten ? sum_t'(COIN_TEN_VAL) : '0);
        // All coins of a cycle are refused together if any would breach the ceiling.
        over     = (coin_sum != '0) && ({1'b0, bal_q} + coin_sum > sum_t'(MAX_BAL));
        coin_in  = (coin_sum != '0) && !over;
        bal_coin = {1'b0, bal_q} + (coin_in ? coin_sum : '0);
        chg_amt  = chg_amount(bal_q);

        state_nx    = state_q;
        bal_nx      = bal_q;
        buy_nx      = buy_q;
        vend_one_nx = 1'b0;
        vend_two_nx = 1'b0;
        chg_ten_nx  = 1'b0;
        chg_one_nx  = 1'b0;
        chg_half_nx = 1'b0;
        rej_nx      = 1'b0;
        deny_nx     = 1'b0;
        vcnt_nx     = '0;
        gcnt_nx     = '0;
        tcnt_nx     = '0;

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                rej_nx   = over;
                bal_nx   = bal_t'(bal_coin);
                state_nx = (bal_coin != '0) ? ST_CREDIT : ST_IDLE;
                if (ev.cancel) begin
                    if (bal_coin != '0)
                        state_nx = ST_CHANGE;
                end else if (ev.get_two || ev.get_one) begin
                    // Affordability uses the pre-coin balance; coins still land this cycle.
                    price = ev.get_two ? sum_t'(PRICE_TWO) : sum_t'(PRICE_ONE);
                    if ({1'b0, bal_q} >= price) begin
                        bal_nx      = bal_t'(bal_coin - price);
                        buy_nx      = 1'b1;
                        vend_two_nx = ev.get_two;
                        vend_one_nx = !ev.get_two;
                        state_nx    = ST_VEND;
                    end else begin
                        deny_nx = 1'b1;
                    end
                end else if (state_q == ST_CREDIT && !coin_in) begin
                    if (tcnt_q == TO_W'(TIMEOUT_CYC - 1))
                        state_nx = ST_CHANGE;
                    else
                        tcnt_nx = tcnt_q + 1'b1;
                end
            end

            ST_VEND: begin
                rej_nx = (coin_sum != '0);
                if (vcnt_q == VC_W'(VEND_CYC - 1)) begin
                    state_nx = (bal_q != '0) ? ST_CREDIT : ST_IDLE;
                end else begin
                    vcnt_nx     = vcnt_q + 1'b1;
                    vend_one_nx = vend_one_q;
                    vend_two_nx = vend_two_q;
                end
            end

            ST_CHANGE: begin
                rej_nx = (coin_sum != '0);
                if (bal_q == '0) begin
                    buy_nx   = 1'b0;
                    state_nx = ST_IDLE;
                end else if (gcnt_q == '0) begin
                    bal_nx      = bal_q - chg_amt;
                    chg_ten_nx  = (chg_amt == bal_t'(COIN_TEN_VAL));
                    chg_one_nx  = (chg_amt == bal_t'(COIN_ONE_VAL));
                    chg_half_nx = (chg_amt == bal_t'(CHG_HALF_VAL));
                    gcnt_nx     = GAP_W'(CHG_GAP - 1);
                end else begin
                    gcnt_nx = gcnt_q - 1'b1;
                end
            end

            default: state_nx = ST_IDLE;
        endcase
    end

    assign coin_val    = bal_q;
    assign state       = state_q;
    assign vend_one    = vend_one_q;
    assign vend_two    = vend_two_q;
    assign chg_ten     = chg_ten_q;
    assign chg_one     = chg_one_q;
    assign chg_half    = chg_half_q;
    assign coin_reject = rej_q;
    assign deny        = deny_q;
    assign buy_flag    = buy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Scoreboard bench for vend_ctrl: a transaction-level model queues the expected
// output events; a negedge monitor pops and compares them as the DUT emits them.
module tb_vend_ctrl;

    localparam int PRICE_ONE   = 5;
    localparam int PRICE_TWO   = 10;
    localparam int MAX_BAL     = 1000;
    localparam int VEND_CYC    = 2;
    localparam int CHG_GAP     = 4;
    localparam int TIMEOUT_CYC = 100;

    localparam int K_REJ  = 0;
    localparam int K_DENY = 1;
    localparam int K_V1   = 2;
    localparam int K_V2   = 3;
    localparam int K_C20  = 4;
    localparam int K_C2   = 5;
    localparam int K_C1   = 6;

    typedef struct {
        int kind;
        int bal;
        bit first;
    } tok_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_one = 1'b0, coin_ten = 1'b0, get_one = 1'b0, get_two = 1'b0, cancle_flag = 1'b0;
    logic [9:0] coin_val;
    logic [1:0] state;
    logic       vend_one, vend_two, chg_ten, chg_one, chg_half, coin_reject, deny, buy_flag;

    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    last_chg = 0;
    int    vlen = 0;
    bit    pv1 = 0, pv2 = 0;
    tok_t  exp_q[$];
    int    mbal = 0;
    bit    mbuy = 0;
    string knames[7] = '{"reject", "deny", "vend_one", "vend_two", "chg_ten", "chg_one", "chg_half"};

    vend_ctrl #(
        .PRICE_ONE   (PRICE_ONE),
        .PRICE_TWO   (PRICE_TWO),
        .MAX_BAL     (MAX_BAL),
        .VEND_CYC    (VEND_CYC),
        .CHG_GAP     (CHG_GAP),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .coin_one    (coin_one),
        .coin_ten    (coin_ten),
        .get_one     (get_one),
        .get_two     (get_two),
        .cancle_flag (cancle_flag),
        .coin_val    (coin_val),
        .state       (state),
        .vend_one    (vend_one),
        .vend_two    (vend_two),
        .chg_ten     (chg_ten),
        .chg_one     (chg_one),
        .chg_half    (chg_half),
        .coin_reject (coin_reject),
        .deny        (deny),
        .buy_flag    (buy_flag)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic got(input int kind);
        tok_t t;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected %s: coin_val=%0d, nothing queued", knames[kind], coin_val);
        end else begin
            t = exp_q.pop_front();
            if (t.kind != kind || t.bal != int'(coin_val)) begin
                bad++;
                $display("FAIL event: got %s coin_val=%0d, expected %s coin_val=%0d",
                         knames[kind], coin_val, knames[t.kind], t.bal);
            end
            if (kind >= K_C20 && !t.first)
                chk("chg_gap", cyc - last_chg, CHG_GAP);
        end
        if (kind >= K_C20)
            last_chg = cyc;
    endtask

    // Monitor: every output event is matched against the head of the queue.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (coin_reject)         got(K_REJ);
            if (deny)                got(K_DENY);
            if (vend_one && !pv1)    got(K_V1);
            if (vend_two && !pv2)    got(K_V2);
            if (chg_ten)             got(K_C20);
            if (chg_one)             got(K_C2);
            if (chg_half)            got(K_C1);
            if (vend_one || vend_two) begin
                vlen++;
            end else if (vlen != 0) begin
                chk("vend_len", vlen, VEND_CYC);
                vlen = 0;
            end
        end
        pv1 = vend_one;
        pv2 = vend_two;
    end

    // Greedy refund of the model balance; returns the number of coins paid.
    function automatic int push_payout();
        int  b = mbal;
        int  n = 0;
        int  v;
        bit  first = 1'b1;
        while (b > 0) begin
            v = (b >= 20) ? 20 : (b >= 2) ? 2 : 1;
            b -= v;
            exp_q.push_back('{(v == 20) ? K_C20 : (v == 2) ? K_C2 : K_C1, b, first});
            first = 1'b0;
            n++;
        end
        mbal = 0;
        mbuy = 1'b0;
        return n;
    endfunction

    // One front-panel event in IDLE/CREDIT; returns the change coin count it triggers.
    function automatic int model_act(input bit o, input bit t, input bit g1, input bit g2, input bit c);
        int c_sum = 2 * o + 20 * t;
        int bc;
        int price;
        int pc = 0;
        bit rej;
        rej = (c_sum > 0) && (mbal + c_sum > MAX_BAL);
        if (rej) c_sum = 0;
        bc = mbal + c_sum;
        if (c) begin
            mbal = bc;
            if (rej) exp_q.push_back('{K_REJ, mbal, 1'b0});
            if (bc > 0) pc = push_payout();
        end else if (g1 || g2) begin
            price = g2 ? PRICE_TWO : PRICE_ONE;
            if (mbal >= price) begin
                mbal = bc - price;
                mbuy = 1'b1;
                if (rej) exp_q.push_back('{K_REJ, mbal, 1'b0});
                exp_q.push_back('{g2 ? K_V2 : K_V1, mbal, 1'b0});
            end else begin
                mbal = bc;
                if (rej) exp_q.push_back('{K_REJ, mbal, 1'b0});
                exp_q.push_back('{K_DENY, mbal, 1'b0});
            end
        end else begin
            mbal = bc;
            if (rej) exp_q.push_back('{K_REJ, mbal, 1'b0});
        end
        return pc;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_pins(input bit o, input bit t, input bit g1, input bit g2, input bit c);
        coin_one    = o;
        coin_ten    = t;
        get_one     = g1;
        get_two     = g2;
        cancle_flag = c;
    endtask

    task automatic settled();
        chk("coin_val", coin_val, mbal);
        chk("state", state, (mbal > 0) ? 1 : 0);
        chk("buy_flag", buy_flag, mbuy);
        chk("strobes_low", {vend_one, vend_two, chg_ten, chg_one, chg_half, coin_reject, deny}, 0);
    endtask

    task automatic act(input bit o, input bit t, input bit g1, input bit g2, input bit c);
        int pc;
        int h;
        pc = model_act(o, t, g1, g2, c);
        h  = $urandom_range(1, 3);
        set_pins(o, t, g1, g2, c);
        tick(h);
        set_pins(0, 0, 0, 0, 0);
        tick(4 * pc + 8);
        settled();
    endtask

    task automatic timeout_wait();
        int pc;
        pc = push_payout();
        tick(TIMEOUT_CYC + 4 * pc + 10);
        settled();
    endtask

    initial begin
        tick(3);
        chk("reset_coin_val", coin_val, 0);
        chk("reset_state", state, 0);
        chk("reset_outputs", {vend_one, vend_two, chg_ten, chg_one, chg_half, coin_reject, deny, buy_flag}, 0);
        reset = 1'b0;
        tick(2);

        // coin_ten latency, coin_one, then get_two with a coin landing mid-vend
        void'(model_act(0, 1, 0, 0, 0));
        set_pins(0, 1, 0, 0, 0);
        tick(1);
        chk("coin_lat_early", coin_val, 0);
        tick(1);
        chk("coin_lat_val", coin_val, 20);
        chk("coin_lat_state", state, 1);
        set_pins(0, 0, 0, 0, 0);
        tick(8);
        settled();
        act(1, 0, 0, 0, 0);
        void'(model_act(0, 0, 0, 1, 0));
        exp_q.push_back('{K_REJ, 12, 1'b0});
        set_pins(0, 0, 0, 1, 0);
        tick(1);
        set_pins(1, 0, 0, 0, 0);
        tick(1);
        chk("vend_start", vend_two, 1);
        chk("vend_bal", coin_val, 12);
        chk("vend_state", state, 2);
        set_pins(0, 0, 0, 0, 0);
        tick(1);
        chk("vend_hold", vend_two, 1);
        chk("vend_coin_reject", coin_reject, 1);
        tick(1);
        chk("vend_end", vend_two, 0);
        chk("vend_exit_state", state, 1);
        tick(6);
        settled();
        act(0, 0, 0, 0, 1);

        // balance 22, get_one, refund 17 = eight chg_one plus one chg_half
        act(0, 1, 0, 0, 0);
        act(1, 0, 0, 0, 0);
        act(0, 0, 1, 0, 0);
        act(0, 0, 0, 0, 1);

        // fill to the ceiling, then both coin types bounce
        for (int i = 0; i < 50; i++) act(0, 1, 0, 0, 0);
        act(0, 1, 0, 0, 0);
        act(1, 0, 0, 0, 0);
        act(0, 0, 0, 0, 1);

        // coin and unaffordable select in the same cycle
        act(0, 1, 0, 1, 0);
        act(0, 0, 0, 0, 1);

        // inactivity refund boundary
        mbal = 2;
        set_pins(1, 0, 0, 0, 0);
        tick(1);
        set_pins(0, 0, 0, 0, 0);
        tick(TIMEOUT_CYC);
        chk("timeout_before", state, 1);
        tick(1);
        chk("timeout_enter", state, 3);
        void'(push_payout());
        tick(5);
        settled();

        // randomized sessions
        for (int i = 0; i < 60; i++) begin
            bit o, t, g1, g2, c;
            if (mbal > 900) begin
                act(0, 0, 0, 0, 1);
            end else if (mbal > 0 && $urandom_range(0, 9) == 0) begin
                timeout_wait();
            end else begin
                do begin
                    o  = ($urandom_range(0, 1) == 0);
                    t  = ($urandom_range(0, 1) == 0);
                    g1 = ($urandom_range(0, 3) == 0);
                    g2 = ($urandom_range(0, 3) == 0);
                    c  = ($urandom_range(0, 7) == 0);
                end while (!(o | t | g1 | g2 | c));
                act(o, t, g1, g2, c);
            end
        end
        if (mbal > 0) act(0, 0, 0, 0, 1);

        // reset during the third chg_ten of a 100-unit refund
        for (int i = 0; i < 5; i++) act(0, 1, 0, 0, 0);
        exp_q.push_back('{K_C20, 80, 1'b1});
        exp_q.push_back('{K_C20, 60, 1'b0});
        set_pins(0, 0, 0, 0, 1);
        tick(1);
        set_pins(0, 0, 0, 0, 0);
        tick(10);
        chk("third_chg_ten", chg_ten, 1);
        chk("third_chg_bal", coin_val, 40);
        reset = 1'b1;
        #1;
        chk("async_rst_outputs", {vend_one, vend_two, chg_ten, chg_one, chg_half, coin_reject, deny, buy_flag}, 0);
        chk("async_rst_state", state, 0);
        chk("async_rst_coin_val", coin_val, 0);
        chk("queue_at_reset", exp_q.size(), 0);
        exp_q.delete();
        mbal = 0;
        mbuy = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(2);
        act(0, 1, 0, 0, 0);
        act(0, 0, 0, 0, 1);

        tick(5);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
